// File: rtl/cmd_frame_manager_pkg.sv
// Shared types and constants for the framed command manager.
package cmd_frame_manager_pkg;

  // Manager FSM states
  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StMemWait,
    StSendAck,
    StSendNak,
    StTxWait,
    StSendRd
  } cfm_state_e;

  localparam logic [7:0] RspAck   = 8'h06;
  localparam logic [7:0] RspNak   = 8'h15;
  localparam logic [7:0] DefCmdWr = 8'h57;  // 'W'
  localparam logic [7:0] DefCmdRd = 8'h52;  // 'R'

endpackage

// File: rtl/frame_timeout_counter.sv
// Saturating cycle counter that flags expiry after TimeoutCyc enabled cycles since the last clear.
module frame_timeout_counter #(
  parameter int unsigned TimeoutCyc = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CntW    = $clog2(TimeoutCyc + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCyc);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCyc - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up while enabled and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag in the last of TimeoutCyc cycles so the owner leaves the state exactly on time
  assign expired_o = enable_i && (cnt_q >= CntLast);

endmodule

// File: rtl/cmd_frame_manager.sv
// Parses W/R command frames from the serial receiver, runs one memory request/ack
// transaction and answers with ACK/NAK (plus read data) through the serial transmitter.
module cmd_frame_manager
  import cmd_frame_manager_pkg::*;
#(
  parameter int unsigned AddrBytes  = 1,
  parameter int unsigned DataBytes  = 1,
  parameter int unsigned TimeoutCyc = 5000000,
  parameter logic [7:0]  CmdWr      = DefCmdWr,
  parameter logic [7:0]  CmdRd      = DefCmdRd
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_done_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [8*AddrBytes-1:0] mem_addr_o,
  output logic [8*DataBytes-1:0] mem_wdata_o,
  input  logic [8*DataBytes-1:0] mem_rdata_i,
  input  logic                   mem_ack_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned AddrW    = 8 * AddrBytes;
  localparam int unsigned DataW    = 8 * DataBytes;
  localparam logic [1:0]  AddrLast = 2'(AddrBytes - 1);
  localparam logic [1:0]  DataLast = 2'(DataBytes - 1);

  cfm_state_e       state_q, state_d;
  logic             is_wr_q;
  logic             rd_pend_q;   // read data bytes still owed after the ACK
  logic [1:0]       byte_cnt_q;
  logic [AddrW-1:0] addr_q;
  logic [DataW-1:0] wdata_q;
  logic [DataW-1:0] rd_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic             err_q;

  logic cmd_ok;
  logic expired;
  logic tmr_clear;
  logic tmr_en;

  assign cmd_ok = (rx_data_i == CmdWr) || (rx_data_i == CmdRd);

  // Timer restarts on any state change or received byte; only runs where a timeout applies
  assign tmr_clear = rx_valid_i || (state_d != state_q);
  assign tmr_en    = (state_q == StGetAddr) || (state_q == StGetData) || (state_q == StMemWait);

  frame_timeout_counter #(
    .TimeoutCyc (TimeoutCyc)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (expired)
  );

  // Next-state decode; expiry is checked before RX so a coinciding byte is dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i) state_d = cmd_ok ? StGetAddr : StSendNak;
      end
      StGetAddr: begin
        if (expired) begin
          state_d = StIdle;
        end else if (rx_valid_i && (byte_cnt_q == AddrLast)) begin
          state_d = is_wr_q ? StGetData : StMemWait;
        end
      end
      StGetData: begin
        if (expired) begin
          state_d = StIdle;
        end else if (rx_valid_i && (byte_cnt_q == DataLast)) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_ack_i) begin
          state_d = StSendAck;
        end else if (expired) begin
          state_d = StSendNak;
        end
      end
      StSendAck: state_d = StTxWait;
      StSendNak: state_d = StTxWait;
      StTxWait: begin
        if (tx_done_i) state_d = rd_pend_q ? StSendRd : StIdle;
      end
      StSendRd: state_d = StTxWait;
      default:  state_d = StIdle;
    endcase
  end

  // FSM state, field shift registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid_i) begin
            is_wr_q    <= (rx_data_i == CmdWr);
            rd_pend_q  <= 1'b0;
            byte_cnt_q <= '0;
            err_q      <= !cmd_ok;
          end
        end
        StGetAddr: begin
          if (expired) begin
            err_q <= 1'b1;
          end else if (rx_valid_i) begin
            addr_q     <= (addr_q << 8) | AddrW'(rx_data_i);
            byte_cnt_q <= (byte_cnt_q == AddrLast) ? 2'd0 : byte_cnt_q + 2'd1;
          end
        end
        StGetData: begin
          if (expired) begin
            err_q <= 1'b1;
          end else if (rx_valid_i) begin
            wdata_q    <= (wdata_q << 8) | DataW'(rx_data_i);
            byte_cnt_q <= (byte_cnt_q == DataLast) ? 2'd0 : byte_cnt_q + 2'd1;
          end
        end
        StMemWait: begin
          if (mem_ack_i) begin
            if (!is_wr_q) begin
              rd_q       <= mem_rdata_i;
              rd_pend_q  <= 1'b1;
              byte_cnt_q <= '0;
            end
          end else if (expired) begin
            err_q <= 1'b1;
          end
        end
        StSendAck: begin
          tx_data_q  <= RspAck;
          tx_start_q <= 1'b1;
        end
        StSendNak: begin
          tx_data_q  <= RspNak;
          tx_start_q <= 1'b1;
        end
        StSendRd: begin
          tx_data_q  <= rd_q[DataW-1 -: 8];
          tx_start_q <= 1'b1;
          rd_q       <= rd_q << 8;
          if (byte_cnt_q == DataLast) begin
            rd_pend_q <= 1'b0;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
      // Request is high for exactly the cycles spent in MEM_WAIT
      mem_req_q <= (state_d == StMemWait);
      mem_we_q  <= (state_d == StMemWait) && is_wr_q;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_cmd_frame_manager.sv
// Randomized self-checking bench for cmd_frame_manager against a frame-level reference model.
module tb_cmd_frame_manager;

  localparam int unsigned AB = 2;
  localparam int unsigned DB = 2;
  localparam int unsigned TO = 100;

  typedef enum int {KWr, KRd, KBad, KTrunc} kind_e;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start, tx_done;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err;

  cmd_frame_manager #(
    .AddrBytes  (AB),
    .DataBytes  (DB),
    .TimeoutCyc (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_done_i   (tx_done),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment state (memory + transmitter models, event log)
  int          cyc = 0;
  int          ack_delay = 1;     // ack on this REQ cycle (1-based); 0 = never
  int          tx_hold_cyc = 0;   // 0 = random transmitter duration
  logic        req_prev = 1'b0;
  int          req_len = 0, req_len_last = 0, req_rise_cyc = 0, n_req = 0, ack_cyc = 0;
  logic        txn_we;
  logic [15:0] txn_addr, txn_wdata;
  logic [7:0]  tx_seen[$];
  int          tx_first_cyc = 0;
  logic        tx_busy = 1'b0;
  int          tx_cnt = 0;
  logic [7:0]  tx_hold;
  int          tx_unstable = 0, tx_overlap = 0;
  int          n_err = 0, err_cyc = -1;
  int          rx_valid_cyc = 0;
  logic [15:0] env_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return ~a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory slave, transmitter and error monitor, all sampled 1 time unit after the edge
  initial begin
    mem_ack = 1'b0; tx_done = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mem_ack = 1'b0;
      tx_done = 1'b0;
      if (!rst_n) begin
        req_prev = 1'b0;
        tx_busy  = 1'b0;
      end else begin
        if (mem_req) begin
          if (!req_prev) begin
            n_req++; req_len = 0; req_rise_cyc = cyc;
            txn_we = mem_we; txn_addr = mem_addr; txn_wdata = mem_wdata;
          end
          req_len++;
          if (ack_delay > 0 && req_len == ack_delay) begin
            mem_ack = 1'b1; ack_cyc = cyc;
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
          end
        end else if (req_prev) begin
          req_len_last = req_len;
        end
        req_prev = mem_req;
        if (tx_start) begin
          if (tx_busy) tx_overlap++;
          if (tx_seen.size() == 0) tx_first_cyc = cyc;
          tx_seen.push_back(tx_data);
          tx_hold = tx_data;
          tx_busy = 1'b1;
          tx_cnt  = (tx_hold_cyc > 0) ? tx_hold_cyc : int'($urandom_range(1, 4));
        end else if (tx_busy) begin
          if (tx_data !== tx_hold) tx_unstable++;
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_done = 1'b1;
            tx_busy = 1'b0;
          end
        end
        if (err) begin
          n_err++;
          err_cyc = cyc;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #2;
    rx_data = b; rx_valid = 1'b1; rx_valid_cyc = cyc;
    @(posedge clk); #2;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || tx_busy) && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    chk($sformatf("%s idle", tag), {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  // One frame: drive bytes, then compare the observed transaction and response to the model
  task automatic run_frame(input string tag, input kind_e k, input logic [15:0] addr,
                           input logic [15:0] data, input int ackd, input int ntrunc,
                           input bit stray);
    logic [7:0] fr[$];
    logic [7:0] exp_tx[$];
    logic [7:0] cmd;
    logic [15:0] rd;
    int err0, req0, nsend, last_rx, exp_err, exp_req;
    bit is_wr;
    err0 = n_err; req0 = n_req; err_cyc = -1;
    tx_seen.delete();
    ack_delay = ackd;
    case (k)
      KWr:     cmd = 8'h57;
      KRd:     cmd = 8'h52;
      KBad: begin
        cmd = data[7:0];
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
      end
      default: cmd = $urandom_range(0, 1) ? 8'h57 : 8'h52;
    endcase
    is_wr = (cmd == 8'h57);
    fr = {cmd, addr[15:8], addr[7:0]};
    if (is_wr) begin
      fr.push_back(data[15:8]);
      fr.push_back(data[7:0]);
    end
    nsend = (k == KBad) ? 1 : fr.size();
    if (k == KTrunc) nsend = (ntrunc >= fr.size()) ? fr.size() - 1 : ntrunc;
    for (int i = 0; i < nsend; i++) send_byte(fr[i], $urandom_range(0, 3));
    last_rx = rx_valid_cyc;
    if (stray) send_byte(8'h57, 0);
    wait_idle(tag);

    exp_req = 0;
    exp_err = 0;
    if (k == KBad) begin
      exp_err = 1;
      exp_tx = {8'h15};
    end else if (k == KTrunc) begin
      exp_err = 1;
      chk($sformatf("%s rx-timeout latency", tag), 64'(err_cyc - (last_rx + 1)), 64'(TO));
    end else begin
      exp_req = 1;
      chk($sformatf("%s we", tag), {63'd0, txn_we}, {63'd0, is_wr});
      chk($sformatf("%s addr", tag), 64'(txn_addr), 64'(addr));
      if (is_wr) chk($sformatf("%s wdata", tag), 64'(txn_wdata), 64'(data));
      chk($sformatf("%s rx->req", tag), 64'(req_rise_cyc - last_rx), 64'd1);
      if (ackd == 0) begin
        exp_err = 1;
        exp_tx = {8'h15};
        chk($sformatf("%s req len", tag), 64'(req_len_last), 64'(TO));
      end else begin
        chk($sformatf("%s req len", tag), 64'(req_len_last), 64'(ackd));
        chk($sformatf("%s ack->tx", tag), 64'(tx_first_cyc - ack_cyc), 64'd2);
        exp_tx = {8'h06};
        if (is_wr) begin
          ref_mem[addr] = data;
        end else begin
          rd = ref_rd(addr);
          exp_tx.push_back(rd[15:8]);
          exp_tx.push_back(rd[7:0]);
        end
      end
    end
    chk($sformatf("%s err count", tag), 64'(n_err - err0), 64'(exp_err));
    chk($sformatf("%s req count", tag), 64'(n_req - req0), 64'(exp_req));
    chk($sformatf("%s tx count", tag), 64'(tx_seen.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < tx_seen.size()) chk($sformatf("%s tx[%0d]", tag, i), 64'(tx_seen[i]), 64'(exp_tx[i]));
  endtask

  function automatic logic [63:0] outs();
    return 64'({tx_data, tx_start, mem_req, mem_we, mem_addr, mem_wdata, busy, err});
  endfunction

  // Asynchronous reset while waiting on memory (in_tx=0) or on the transmitter (in_tx=1)
  task automatic reset_mid(input string tag, input bit in_tx);
    logic [15:0] a, d;
    int n = 0, err0, tx0;
    a = 16'h3000 | 16'($urandom_range(0, 7));
    d = 16'($urandom);
    tx_hold_cyc = in_tx ? 30 : 0;
    ack_delay   = in_tx ? 1 : 0;
    tx_seen.delete();
    send_byte(8'h57, 0); send_byte(a[15:8], 0); send_byte(a[7:0], 0);
    send_byte(d[15:8], 0); send_byte(d[7:0], 0);
    while (!(in_tx ? tx_busy : mem_req) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk($sformatf("%s reached", tag), 64'(n < 50), 64'd1);
    if (in_tx) ref_mem[a] = d;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0;
    #1; chk($sformatf("%s outs in reset", tag), outs(), 64'd0);
    err0 = n_err; tx0 = tx_seen.size();
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    tx_hold_cyc = 0;
    repeat (5) @(posedge clk);
    #2;
    chk($sformatf("%s silent after reset", tag), {outs(), 32'(n_err - err0), 32'(tx_seen.size() - tx0)}, 64'd0);
    run_frame($sformatf("%s recover wr", tag), KWr, 16'h0010, 16'h00AB, 3, 0, 0);
    run_frame($sformatf("%s readback", tag), KRd, a, 16'h0, 2, 0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    kind_e k;
    int r, ackd;
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = '0;
    #3 rst_n = 1'b0;
    #1 chk("reset outs", outs(), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("reset idle", outs(), 64'd0);

    run_frame("t1 write", KWr, 16'h0010, 16'h00AB, 3, 0, 1);
    env_mem[16'h1234] = 16'hBEEF;
    ref_mem[16'h1234] = 16'hBEEF;
    run_frame("t2 read", KRd, 16'h1234, 16'h0, 2, 0, 0);
    run_frame("t3 bad cmd", KBad, 16'h0, 16'h0041, 1, 0, 0);
    run_frame("t3 next", KWr, 16'h0022, 16'h5566, 1, 0, 0);
    run_frame("t4 rx timeout", KTrunc, 16'h0010, 16'h0, 1, 2, 0);
    run_frame("t5 mem timeout", KWr, 16'h0044, 16'h7788, 0, 0, 0);
    reset_mid("t6 memwait", 1'b0);
    reset_mid("t6 txwait", 1'b1);

    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      k = (r < 4) ? KWr : (r < 7) ? KRd : (r < 8) ? KBad : KTrunc;
      ackd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      run_frame($sformatf("rnd%0d", i), k, 16'h2000 | 16'($urandom_range(0, 7)),
                16'($urandom), ackd, $urandom_range(1, 4), 0);
    end

    chk("tx data stable", 64'(tx_unstable), 64'd0);
    chk("tx start overlap", 64'(tx_overlap), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
